fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter and flush sequencer for the write side of the asynchronous FIFO. Shares the single `fifo_write` port (`wr_enable`, `flush`, data) among `NUM_REQ` requesters in the write-clock domain. Stalls all requesters on `full`. Sequences a clean flush of the write pointer before arbitration resumes.

## Interface
- `DATA_WIDTH`, 8: width of each requester's data word and of `wr_data`.
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 4: maximum consecutive beats per grant when bursting is compiled in, 1..15.
- `FLUSH_WAIT`, 2: idle cycles after the flush strobe so the registered `full` settles, 1..7.

Ports:
- `w_clk` in 1: write-domain clock. All logic is on its rising edge.
- `wreset` in 1: reset, synchronous and active-high.
- `req` in NUM_REQ: per-requester write request. Level-sensitive; held until accepted.
- `req_data` in NUM_REQ*DATA_WIDTH: packed data. Requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
- `flush_req` in 1: single-cycle pulse requesting a FIFO flush.
- `full` in 1: FIFO full flag from the write side.
- `grant` out NUM_REQ: one-hot accept. A beat from requester i is consumed in the cycle where `req[i]` and `grant[i]` are both high.
- `wr_enable` out 1: FIFO write enable.
- `wr_data` out DATA_WIDTH: data of the granted requester; 0 when there is no grant.
- `flush` out 1: FIFO flush, always asserted together with `wr_enable`.
- `busy` out 1: high in FLUSH and FLUSH_WT.

## Operation
- State machine: ARB, BURST, FLUSH, FLUSH_WT. Reset state is ARB.
- Registered state:
  - `rr_ptr`: $clog2(NUM_REQ) bits, reset 0.
  - `owner`: lock owner index, reset 0.
  - `beat_cnt`: 4 bits, reset 0.
  - `wait_cnt`: 3 bits, reset 0.
- ARB:
  - If `full`=0, grant the first asserted `req` found by searching upward from `rr_ptr`, with modulo-NUM_REQ wrap.
  - `grant`, `wr_enable` and `wr_data` are combinational from state and inputs (zero-cycle accept).
  - On accept by requester i without bursting: `rr_ptr` <= (i+1) mod NUM_REQ and the FSM stays in ARB.
- BURST (only with the configuration macro below):
  - Grant stays with `owner` while `req[owner]`=1 and `beat_cnt` < MAX_BURST.
  - `full`=1: all grants are 0; `owner` and `beat_cnt` hold.
  - Exit to ARB when `req[owner]` drops, or after the beat that makes `beat_cnt`=MAX_BURST. On exit, `rr_ptr` <= (owner+1) mod NUM_REQ and `beat_cnt` <= 0.
- FLUSH:
  - Entered from ARB or BURST on the cycle after `flush_req`=1.
  - For exactly one cycle: `wr_enable`=1, `flush`=1, `grant`=0.
  - Lock and `beat_cnt` clear; `rr_ptr` is unchanged.
  - Next state is FLUSH_WT with `wait_cnt` <= 0.
- FLUSH_WT:
  - `grant`=0, `wr_enable`=0.
  - `wait_cnt` increments each cycle; go to ARB when `wait_cnt`=FLUSH_WAIT-1.
  - `flush_req` is ignored in FLUSH and FLUSH_WT.
- Simultaneous `flush_req` and `req`: the flush wins. No grant is issued in the `flush_req` cycle and no beat is accepted.
- `wr_enable` is never asserted while `full`=1, except for the flush strobe.

## Timing
- Reset: while `wreset`=1, all outputs are 0. Registers load reset values at the edge.
- Reset mid-burst or mid-flush: the FSM returns to ARB on the next edge with no further strobe.
- Accept latency: 0 cycles from `req` to `grant` when `full`=0 in ARB or BURST.
- Flush sequence from the `flush_req` cycle T:
  - cycle T+1: flush strobe.
  - cycles T+2 .. T+1+FLUSH_WAIT: wait.
  - cycle T+2+FLUSH_WAIT: first possible grant.
- `full` assertion mid-cycle: its effect on `grant` is combinational within the same cycle.

## Configuration
- `FIFO_WR_ARB_BURST_EN` defined:
  - The BURST state and `beat_cnt` are compiled in.
  - The winner of an ARB accept enters BURST with `owner` <= i and `beat_cnt` <= 1.
- Not defined:
  - BURST and `beat_cnt` are absent.
  - Every accepted beat rotates `rr_ptr`, so arbitration is strict per-beat round-robin.
  - `MAX_BURST` is unused.

## Test plan
- Reset, then `req`=4'b1111 for 4 cycles with `full`=0, no burst -> grants in order 0, 1, 2, 3; `wr_data` matches each requester's word.
- Burst enabled, MAX_BURST=4, `req`=4'b0011 held -> 4 beats to requester 0, then 4 to requester 1; `rr_ptr` reads 2 afterwards.
- `full`=1 for 3 cycles during requester 2's second burst beat -> `grant`=0 and `wr_enable`=0 for those 3 cycles; the burst then resumes with 2 beats remaining.
- `flush_req` and `req[1]` in the same cycle T -> no grant at T; `wr_enable`=`flush`=1 at T+1; `busy`=1 at T+1..T+3; requester 1 granted at T+4 (FLUSH_WAIT=2).
- `wreset` asserted during FLUSH_WT -> all outputs 0 in that cycle; ARB with `rr_ptr`=0 afterwards; `flush` is not re-strobed.
- `req`=4'b1000 with `rr_ptr`=3, then `req`=4'b0001 -> requester 3 is granted, then the search wraps and requester 0 is granted the next cycle.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with a flush sequencer for the async FIFO write side.
// Define FIFO_WR_ARB_BURST_EN to compile in per-grant bursting (BURST state, beat counter).
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int FLUSH_WAIT = 2
) (
  input  logic                          w_clk,
  input  logic                          wreset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          flush_req,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          wr_enable,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          flush,
  output logic                          busy,
  output logic [1:0]                    o_dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]    o_dbg_rr_ptr
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [2:0] WAIT_LAST = 3'(FLUSH_WAIT - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fifo_wr_arbiter: NUM_REQ out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("fifo_wr_arbiter: MAX_BURST out of range");
  end
  if (FLUSH_WAIT < 1 || FLUSH_WAIT > 7) begin : g_bad_flush_wait
    $error("fifo_wr_arbiter: FLUSH_WAIT out of range");
  end

  typedef enum logic [1:0] {
    ST_ARB      = 2'd0,
    ST_BURST    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_FLUSH_WT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   w_rr_nxt;
  logic [2:0]         r_wait_cnt;
  logic [2:0]         w_wait_nxt;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [3:0]         r_beat_cnt;
  logic [3:0]         w_beat_nxt;
`endif

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_cand;
  logic               w_gnt_en;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_flush;
  logic               w_busy;
  logic [NUM_REQ-1:0] w_onehot;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int step);
    int s;
    s = int'(p) + step;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  // First asserted request at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = wrap_add(r_rr_ptr, k);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_wait_nxt  = r_wait_cnt;
`ifdef FIFO_WR_ARB_BURST_EN
    w_owner_nxt = r_owner;
    w_beat_nxt  = r_beat_cnt;
`endif
    w_gnt_en    = 1'b0;
    w_gnt_idx   = '0;
    w_flush     = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_ARB: begin
        if (flush_req) begin
          w_state_nxt = ST_FLUSH;
        end else if (!full && w_found) begin
          w_gnt_en  = 1'b1;
          w_gnt_idx = w_win;
`ifdef FIFO_WR_ARB_BURST_EN
          if (MAX_BURST > 1) begin
            w_state_nxt = ST_BURST;
            w_owner_nxt = w_win;
            w_beat_nxt  = 4'd1;
          end else begin
            w_rr_nxt = wrap_add(w_win, 1);
          end
`else
          w_rr_nxt = wrap_add(w_win, 1);
`endif
        end
      end
      ST_BURST: begin
`ifdef FIFO_WR_ARB_BURST_EN
        if (flush_req) begin
          w_state_nxt = ST_FLUSH;
        end else if (!req[r_owner]) begin
          w_state_nxt = ST_ARB;
          w_rr_nxt    = wrap_add(r_owner, 1);
          w_beat_nxt  = 4'd0;
        end else if (!full) begin
          w_gnt_en  = 1'b1;
          w_gnt_idx = r_owner;
          if (r_beat_cnt == BEAT_LAST) begin
            w_state_nxt = ST_ARB;
            w_rr_nxt    = wrap_add(r_owner, 1);
            w_beat_nxt  = 4'd0;
          end else begin
            w_beat_nxt = r_beat_cnt + 4'd1;
          end
        end
`else
        w_state_nxt = ST_ARB;
`endif
      end
      ST_FLUSH: begin
        w_flush     = 1'b1;
        w_busy      = 1'b1;
        w_state_nxt = ST_FLUSH_WT;
        w_wait_nxt  = 3'd0;
`ifdef FIFO_WR_ARB_BURST_EN
        w_owner_nxt = '0;
        w_beat_nxt  = 4'd0;
`endif
      end
      ST_FLUSH_WT: begin
        w_busy = 1'b1;
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_ARB;
          w_wait_nxt  = 3'd0;
        end else begin
          w_wait_nxt = r_wait_cnt + 3'd1;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (wreset) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_wait_cnt <= 3'd0;
`ifdef FIFO_WR_ARB_BURST_EN
      r_owner    <= '0;
      r_beat_cnt <= 4'd0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_wait_cnt <= w_wait_nxt;
`ifdef FIFO_WR_ARB_BURST_EN
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_nxt;
`endif
    end
  end

  always_comb begin
    w_onehot            = '0;
    w_onehot[w_gnt_idx] = 1'b1;
  end

  // Outputs are forced low while reset is held, regardless of stale state.
  assign grant        = (!wreset && w_gnt_en) ? w_onehot : '0;
  assign wr_enable    = !wreset && (w_gnt_en || w_flush);
  assign flush        = !wreset && w_flush;
  assign busy         = !wreset && w_busy;
  assign wr_data      = (!wreset && w_gnt_en) ?
                        req_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_dbg_state  = wreset ? 2'd0 : r_state;
  assign o_dbg_rr_ptr = wreset ? '0 : r_rr_ptr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected writes queued by the driver, checked by a monitor.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int EW = 1 + NR + DW;

  logic           w_clk = 1'b0;
  logic           wreset = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR*DW-1:0] req_data;
  logic           flush_req = 1'b0;
  logic           full = 1'b0;
  logic [NR-1:0]  grant;
  logic           wr_enable;
  logic [DW-1:0]  wr_data;
  logic           flush;
  logic           busy;
  logic [1:0]     o_dbg_state;
  logic [1:0]     o_dbg_rr_ptr;

  logic [EW-1:0]  exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;

  // Requester i presents word 0x11*(i+1).
  assign req_data = {8'h44, 8'h33, 8'h22, 8'h11};

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4), .FLUSH_WAIT(2)) dut (
    .w_clk(w_clk), .wreset(wreset), .req(req), .req_data(req_data),
    .flush_req(flush_req), .full(full), .grant(grant), .wr_enable(wr_enable),
    .wr_data(wr_data), .flush(flush), .busy(busy),
    .o_dbg_state(o_dbg_state), .o_dbg_rr_ptr(o_dbg_rr_ptr)
  );

  always #5 w_clk = ~w_clk;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [EW-1:0] mk(input logic f, input logic [NR-1:0] g, input logic [DW-1:0] d);
    return {f, g, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: every write-port strobe must match the oldest expected beat.
  always @(negedge w_clk) begin
    if (wr_enable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {19'd0, flush, grant, wr_data}, 32'hFFFF_FFFF);
      end else begin
        chk("write_beat", {19'd0, flush, grant, wr_data}, {19'd0, exp_q.pop_front()});
      end
    end else if (grant != '0) begin
      chk("grant_without_wr_enable", {28'd0, grant}, 32'd0);
    end
  end

  task automatic step(input logic rst, input logic [NR-1:0] r, input logic fr, input logic fl);
    @(posedge w_clk);
    #1;
    wreset    = rst;
    req       = r;
    flush_req = fr;
    full      = fl;
    @(negedge w_clk);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_grant"}, {28'd0, grant}, 32'd0);
    chk({name, "_wr_enable"}, {31'd0, wr_enable}, 32'd0);
  endtask

  initial begin
    // Reset with requests and a flush pulse present: everything must stay low.
    step(1'b1, 4'b1111, 1'b1, 1'b1);
    chk_quiet("reset");
    chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 4'b1111, 1'b0, 1'b0);
    chk("reset_rr_ptr", {30'd0, o_dbg_rr_ptr}, 32'd0);
    chk("reset_state", {30'd0, o_dbg_state}, 32'd0);

`ifdef FIFO_WR_ARB_BURST_EN
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'b0001, 8'h11));
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'b0010, 8'h22));
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0011, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("burst_rr_ptr", {30'd0, o_dbg_rr_ptr}, 32'd2);
    chk("burst_state", {30'd0, o_dbg_state}, 32'd0);
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100, 1'b0, 1'b1);
      chk_quiet("burst_full");
    end
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("burst_end_rr_ptr", {30'd0, o_dbg_rr_ptr}, 32'd3);
    chk("burst_end_state", {30'd0, o_dbg_state}, 32'd0);
`else
    // Per-beat round robin over all four requesters.
    exp_q.push_back(mk(1'b0, 4'b0001, 8'h11));
    exp_q.push_back(mk(1'b0, 4'b0010, 8'h22));
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    exp_q.push_back(mk(1'b0, 4'b1000, 8'h44));
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rr_after_four", {30'd0, o_dbg_rr_ptr}, 32'd0);

    // Pointer walk 2 -> 3 -> 0 -> 1, then a search from 1 that wraps to 0.
    exp_q.push_back(mk(1'b0, 4'b0100, 8'h33));
    exp_q.push_back(mk(1'b0, 4'b1000, 8'h44));
    exp_q.push_back(mk(1'b0, 4'b0001, 8'h11));
    exp_q.push_back(mk(1'b0, 4'b0001, 8'h11));
    step(1'b0, 4'b0100, 1'b0, 1'b0);
    step(1'b0, 4'b1001, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rr_after_wrap", {30'd0, o_dbg_rr_ptr}, 32'd1);

    // full stalls everyone; arbitration resumes from the held pointer.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, 1'b0, 1'b1);
      chk_quiet("full_stall");
    end
    exp_q.push_back(mk(1'b0, 4'b0010, 8'h22));
    step(1'b0, 4'b1111, 1'b0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("rr_after_full", {30'd0, o_dbg_rr_ptr}, 32'd2);

    // Flush beats a simultaneous request; strobe ignores full; a pulse in the wait is ignored.
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk_quiet("flush_req_cycle");
    chk("flush_req_busy", {31'd0, busy}, 32'd0);
    exp_q.push_back(mk(1'b1, 4'b0000, 8'h00));
    step(1'b0, 4'b0010, 1'b0, 1'b1);
    chk("strobe_busy", {31'd0, busy}, 32'd1);
    chk("strobe_flush", {31'd0, flush}, 32'd1);
    step(1'b0, 4'b0010, 1'b1, 1'b0);
    chk("wait1_busy", {31'd0, busy}, 32'd1);
    chk_quiet("wait1");
    step(1'b0, 4'b0010, 1'b0, 1'b0);
    chk("wait2_busy", {31'd0, busy}, 32'd1);
    chk_quiet("wait2");
    exp_q.push_back(mk(1'b0, 4'b0010, 8'h22));
    step(1'b0, 4'b0010, 1'b0, 1'b0);
    chk("resume_busy", {31'd0, busy}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);

    // Reset during the flush wait: outputs low, ARB with pointer 0, no second strobe.
    step(1'b0, 4'b0000, 1'b1, 1'b0);
    exp_q.push_back(mk(1'b1, 4'b0000, 8'h00));
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 4'b0000, 1'b0, 1'b0);
    chk("rst_wt_busy", {31'd0, busy}, 32'd0);
    chk("rst_wt_flush", {31'd0, flush}, 32'd0);
    chk("rst_wt_wr_enable", {31'd0, wr_enable}, 32'd0);
    step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_state", {30'd0, o_dbg_state}, 32'd0);
    chk("post_rst_rr_ptr", {30'd0, o_dbg_rr_ptr}, 32'd0);
    exp_q.push_back(mk(1'b0, 4'b0010, 8'h22));
    step(1'b0, 4'b0110, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b0, 1'b0);
    chk("beats_outstanding", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
